// File: rtl/gcn_pkg.sv
// Shared types and defaults for the GCN compute top and its memory-side responder.
package gcn_pkg;

  localparam int DEF_WEIGHT_ROWS     = 96;
  localparam int DEF_WEIGHT_COLS     = 3;
  localparam int DEF_FEATURE_ROWS    = 6;
  localparam int DEF_DATA_WIDTH      = 5;
  localparam int DEF_ADDRESS_WIDTH   = 13;
  localparam int DEF_COO_NUM_OF_COLS = 6;

  localparam int WM_BASE = 0;
  localparam int FM_BASE = 512;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_WM   = 2'd1,
    SEL_FM   = 2'd2
  } rsel_t;

  typedef logic [DEF_WEIGHT_ROWS-1:0][DEF_DATA_WIDTH-1:0] vec_t;

endpackage

// File: rtl/gcn_data_responder_vector_bank.sv
// Vector storage: element-granular write port, whole-vector registered read.
module vector_bank #(
  parameter int DEPTH = 3,
  parameter int ROWS  = 96,
  parameter int DW    = 5,
  parameter int AW    = 13,
  parameter int EW    = 7,
  parameter int VW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [AW-1:0]            i_wr_vec,
  input  logic [EW-1:0]            i_wr_elem,
  input  logic [DW-1:0]            i_wr_data,
  input  logic                     i_rd_en,
  input  logic [VW-1:0]            i_rd_vec,
  output logic [ROWS-1:0][DW-1:0]  o_rd_data
);

  logic [ROWS-1:0][DW-1:0] r_mem [DEPTH];
  logic [ROWS-1:0][DW-1:0] r_rd_data;
  logic                    w_wr_ok;

  assign w_wr_ok = i_wr_en && (i_wr_vec < AW'(DEPTH)) && (i_wr_elem < EW'(ROWS));

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[i_wr_vec[VW-1:0]][i_wr_elem] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_vec];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gcn_data_responder.sv
// Memory-side responder: WM/FM vector banks, COO table, LOAD/SERVE gating FSM.
module gcn_data_responder #(
  parameter int WEIGHT_ROWS     = gcn_pkg::DEF_WEIGHT_ROWS,
  parameter int WEIGHT_COLS     = gcn_pkg::DEF_WEIGHT_COLS,
  parameter int FEATURE_ROWS    = gcn_pkg::DEF_FEATURE_ROWS,
  parameter int DATA_WIDTH      = gcn_pkg::DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH   = gcn_pkg::DEF_ADDRESS_WIDTH,
  parameter int WM_BASE         = gcn_pkg::WM_BASE,
  parameter int FM_BASE         = gcn_pkg::FM_BASE,
  parameter int COO_NUM_OF_COLS = gcn_pkg::DEF_COO_NUM_OF_COLS,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
  parameter int ELEM_BW         = $clog2(WEIGHT_ROWS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  load_start,
  input  logic                                  load_done,
  output logic                                  load_ready,
  input  logic                                  load_wr_en,
  input  logic                                  load_sel,
  input  logic [ADDRESS_WIDTH-1:0]              load_vec,
  input  logic [ELEM_BW-1:0]                    load_elem,
  input  logic [DATA_WIDTH-1:0]                 load_data,
  input  logic                                  coo_wr_en,
  input  logic [COO_BW-1:0]                     coo_wr_col,
  input  logic [1:0][COO_BW-1:0]                coo_wr_data,
  input  logic                                  enable_read,
  input  logic [ADDRESS_WIDTH-1:0]              read_address,
  output logic [WEIGHT_ROWS-1:0][DATA_WIDTH-1:0] data_in,
  output logic                                  data_valid,
  output logic                                  addr_err,
  input  logic [COO_BW-1:0]                     coo_address,
  output logic [1:0][COO_BW-1:0]                coo_in,
  output logic                                  coo_err
);

  import gcn_pkg::*;

  localparam int WM_VW = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam int FM_VW = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;

  state_t                              r_state;
  state_t                              w_next;
  rsel_t                               r_sel;
  logic                                r_load_ready;
  logic                                r_valid;
  logic                                r_addr_err;
  logic                                r_coo_err;
  logic [1:0][COO_BW-1:0]              r_coo_in;
  logic [1:0][COO_BW-1:0]              r_coo_mem [COO_NUM_OF_COLS];
  logic [WEIGHT_ROWS-1:0][DATA_WIDTH-1:0] w_wm_data;
  logic [WEIGHT_ROWS-1:0][DATA_WIDTH-1:0] w_fm_data;
  logic [ADDRESS_WIDTH-1:0]            w_wm_off;
  logic [ADDRESS_WIDTH-1:0]            w_fm_off;
  logic                                w_wm_hit;
  logic                                w_fm_hit;
  logic                                w_rd_acc;
  logic                                w_wr_ok;
  logic                                w_coo_ok;

  // Unsigned offset compare also rejects addresses below each base (wraps high).
  assign w_wm_off = read_address - ADDRESS_WIDTH'(WM_BASE);
  assign w_fm_off = read_address - ADDRESS_WIDTH'(FM_BASE);
  assign w_wm_hit = w_wm_off < ADDRESS_WIDTH'(WEIGHT_COLS);
  assign w_fm_hit = w_fm_off < ADDRESS_WIDTH'(FEATURE_ROWS);
  assign w_rd_acc = (r_state == SERVE) && enable_read;
  assign w_wr_ok  = (r_state == LOAD) && !reset;
  assign w_coo_ok = coo_address < COO_BW'(COO_NUM_OF_COLS);

  always_comb begin
    w_next = r_state;
    if (load_start)     w_next = LOAD;
    else if (load_done) w_next = SERVE;
  end

  vector_bank #(
    .DEPTH(WEIGHT_COLS), .ROWS(WEIGHT_ROWS), .DW(DATA_WIDTH),
    .AW(ADDRESS_WIDTH), .EW(ELEM_BW), .VW(WM_VW)
  ) u_wm (
    .clk       (clk),
    .i_wr_en   (w_wr_ok && load_wr_en && !load_sel),
    .i_wr_vec  (load_vec),
    .i_wr_elem (load_elem),
    .i_wr_data (load_data),
    .i_rd_en   (w_rd_acc && w_wm_hit),
    .i_rd_vec  (w_wm_off[WM_VW-1:0]),
    .o_rd_data (w_wm_data)
  );

  vector_bank #(
    .DEPTH(FEATURE_ROWS), .ROWS(WEIGHT_ROWS), .DW(DATA_WIDTH),
    .AW(ADDRESS_WIDTH), .EW(ELEM_BW), .VW(FM_VW)
  ) u_fm (
    .clk       (clk),
    .i_wr_en   (w_wr_ok && load_wr_en && load_sel),
    .i_wr_vec  (load_vec),
    .i_wr_elem (load_elem),
    .i_wr_data (load_data),
    .i_rd_en   (w_rd_acc && !w_wm_hit && w_fm_hit),
    .i_rd_vec  (w_fm_off[FM_VW-1:0]),
    .o_rd_data (w_fm_data)
  );

  always_ff @(posedge clk) begin
    if (w_wr_ok && coo_wr_en && (coo_wr_col < COO_BW'(COO_NUM_OF_COLS)))
      r_coo_mem[coo_wr_col] <= coo_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= LOAD;
      r_load_ready <= 1'b1;
      r_valid      <= 1'b0;
      r_addr_err   <= 1'b0;
      r_sel        <= SEL_NONE;
      r_coo_in     <= '0;
      r_coo_err    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_load_ready <= (w_next == LOAD);
      r_valid      <= w_rd_acc;
      if (w_rd_acc) begin
        r_addr_err <= !(w_wm_hit || w_fm_hit);
        r_sel      <= w_wm_hit ? SEL_WM : (w_fm_hit ? SEL_FM : SEL_NONE);
      end
      r_coo_in  <= w_coo_ok ? r_coo_mem[coo_address] : '0;
      r_coo_err <= !w_coo_ok;
    end
  end

  // Bank read registers hold between requests, so the registered select alone keeps data_in stable.
  always_comb begin
    data_in = '0;
    case (r_sel)
      SEL_WM:  data_in = w_wm_data;
      SEL_FM:  data_in = w_fm_data;
      default: data_in = '0;
    endcase
  end

  assign load_ready = r_load_ready;
  assign data_valid = r_valid;
  assign addr_err   = r_addr_err;
  assign coo_in     = r_coo_in;
  assign coo_err    = r_coo_err;

endmodule

// File: tb/tb_gcn_data_responder.sv
// Directed bench for gcn_data_responder: load/serve round trips, range errors, COO, FSM control.
module tb_gcn_data_responder;

  logic                clk = 1'b0;
  logic                reset;
  logic                load_start, load_done, load_ready;
  logic                load_wr_en, load_sel;
  logic [12:0]         load_vec;
  logic [6:0]          load_elem;
  logic [4:0]          load_data;
  logic                coo_wr_en;
  logic [2:0]          coo_wr_col;
  logic [1:0][2:0]     coo_wr_data;
  logic                enable_read;
  logic [12:0]         read_address;
  logic [95:0][4:0]    data_in;
  logic                data_valid, addr_err;
  logic [2:0]          coo_address;
  logic [1:0][2:0]     coo_in;
  logic                coo_err;

  int errors = 0;
  int checks = 0;

  logic [12:0] b2b_addr [4];
  logic [4:0]  b2b_exp  [4];

  gcn_data_responder dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_done    (load_done),
    .load_ready   (load_ready),
    .load_wr_en   (load_wr_en),
    .load_sel     (load_sel),
    .load_vec     (load_vec),
    .load_elem    (load_elem),
    .load_data    (load_data),
    .coo_wr_en    (coo_wr_en),
    .coo_wr_col   (coo_wr_col),
    .coo_wr_data  (coo_wr_data),
    .enable_read  (enable_read),
    .read_address (read_address),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .addr_err     (addr_err),
    .coo_address  (coo_address),
    .coo_in       (coo_in),
    .coo_err      (coo_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [479:0] obs, input logic [479:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_done = 1'b0;
    load_wr_en = 1'b0; load_sel = 1'b0; load_vec = '0; load_elem = '0; load_data = '0;
    coo_wr_en = 1'b0; coo_wr_col = '0; coo_wr_data = '0;
    enable_read = 1'b0; read_address = '0; coo_address = 3'd2;
    b2b_addr[0] = 13'd0;   b2b_exp[0] = 5'd7;
    b2b_addr[1] = 13'd1;   b2b_exp[1] = 5'd0;
    b2b_addr[2] = 13'd2;   b2b_exp[2] = 5'd9;
    b2b_addr[3] = 13'd512; b2b_exp[3] = 5'd11;

    // Reset for two cycles
    tick(); tick();
    chk("rst_load_ready", load_ready, 1);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_addr_err",   addr_err,   0);
    chk("rst_data_in",    data_in,    0);
    chk("rst_coo_in",     coo_in,     0);
    chk("rst_coo_err",    coo_err,    0);

    // Read in LOAD is ignored
    reset = 1'b0; enable_read = 1'b1; read_address = 13'd0;
    tick();
    chk("load_rd_valid", data_valid, 0);
    chk("load_rd_err",   addr_err,   0);
    chk("load_ready_hi", load_ready, 1);
    enable_read = 1'b0;

    // Load WM column 1 and a few marker elements, plus COO column 2
    load_wr_en = 1'b1; load_sel = 1'b0; load_vec = 13'd1;
    for (int k = 0; k < 96; k++) begin
      load_elem = 7'(k); load_data = 5'(k % 32);
      tick();
    end
    load_vec = 13'd0; load_elem = 7'd0; load_data = 5'd7;
    coo_wr_en = 1'b1; coo_wr_col = 3'd2; coo_wr_data = {3'd1, 3'd4};
    tick();
    load_vec = 13'd2; load_data = 5'd9;
    coo_wr_col = 3'd6; coo_wr_data = {3'd7, 3'd7};
    tick();
    coo_wr_en = 1'b0;
    load_sel = 1'b1; load_vec = 13'd0; load_data = 5'd11;
    tick();
    load_vec = 13'd5;
    for (int k = 0; k < 96; k++) begin
      load_elem = 7'(k); load_data = 5'(31 - (k % 32));
      load_done = (k == 95);
      tick();
    end
    load_wr_en = 1'b0; load_done = 1'b0;
    chk("serve_ready_lo", load_ready, 0);
    chk("coo_load",       coo_in,     {3'd1, 3'd4});

    // WM/FM round trip
    enable_read = 1'b1; read_address = 13'd1;
    tick();
    chk("rd1_valid",  data_valid,  1);
    chk("rd1_e95",    data_in[95], 31);
    chk("rd1_e0",     data_in[0],  0);
    chk("rd1_err",    addr_err,    0);
    read_address = 13'd517;
    tick();
    chk("rd517_e0",   data_in[0],  31);
    chk("rd517_e95",  data_in[95], 0);
    enable_read = 1'b0;
    tick();
    chk("idle_valid", data_valid,  0);
    chk("idle_hold",  data_in[0],  31);

    // Back-to-back reads
    enable_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read_address = b2b_addr[i];
      tick();
      chk("b2b_valid", data_valid, 1);
      chk("b2b_e0",    data_in[0], b2b_exp[i]);
    end
    enable_read = 1'b0;
    tick();
    chk("b2b_end_valid", data_valid, 0);

    // Range errors
    enable_read = 1'b1; read_address = 13'd3;
    tick();
    chk("err3_data", data_in,  0);
    chk("err3_flag", addr_err, 1);
    read_address = 13'd518;
    tick();
    chk("err518_data", data_in,  0);
    chk("err518_flag", addr_err, 1);
    read_address = 13'd1;
    tick();
    chk("err_clear",  addr_err,    0);
    chk("err_clr_e95", data_in[95], 31);
    enable_read = 1'b0;

    coo_address = 3'd6;
    tick();
    chk("coo6_data", coo_in,  0);
    chk("coo6_err",  coo_err, 1);
    coo_address = 3'd2;
    tick();
    chk("coo_serve",     coo_in,  {3'd1, 3'd4});
    chk("coo_serve_err", coo_err, 0);

    // Writes in SERVE are ignored
    load_wr_en = 1'b1; load_sel = 1'b0; load_vec = 13'd1; load_elem = 7'd95; load_data = 5'd5;
    coo_wr_en = 1'b1; coo_wr_col = 3'd2; coo_wr_data = {3'd7, 3'd7};
    tick();
    load_wr_en = 1'b0; coo_wr_en = 1'b0;
    enable_read = 1'b1; read_address = 13'd1;
    tick();
    chk("serve_wr_wm",  data_in[95], 31);
    chk("serve_wr_coo", coo_in,      {3'd1, 3'd4});

    // load_start with a request at the same edge
    read_address = 13'd2; load_start = 1'b1;
    tick();
    chk("inflight_valid", data_valid, 1);
    chk("inflight_e0",    data_in[0], 9);
    chk("inflight_ready", load_ready, 1);
    load_start = 1'b0; read_address = 13'd512;
    tick();
    chk("after_start_valid", data_valid, 0);
    chk("after_start_hold",  data_in[0], 9);
    enable_read = 1'b0;

    // load_start and load_done together stay in LOAD
    load_start = 1'b1; load_done = 1'b1;
    tick();
    load_start = 1'b0; load_done = 1'b0;
    chk("both_ready", load_ready, 1);
    enable_read = 1'b1; read_address = 13'd0;
    tick();
    chk("both_rd_valid", data_valid, 0);
    enable_read = 1'b0;

    // Back to SERVE, then reset mid-SERVE
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("reserve_ready", load_ready, 0);
    enable_read = 1'b1; read_address = 13'd512;
    tick();
    chk("reserve_e0", data_in[0], 11);
    reset = 1'b1;
    tick();
    chk("midrst_ready",   load_ready, 1);
    chk("midrst_valid",   data_valid, 0);
    chk("midrst_data",    data_in,    0);
    chk("midrst_coo",     coo_in,     0);
    chk("midrst_addrerr", addr_err,   0);
    reset = 1'b0; enable_read = 1'b0; load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("midrst_coo_kept", coo_in, {3'd1, 3'd4});
    enable_read = 1'b1; read_address = 13'd517;
    tick();
    chk("kept_fm_valid", data_valid, 1);
    chk("kept_fm_e0",    data_in[0], 31);
    read_address = 13'd2;
    tick();
    chk("kept_wm_e0",    data_in[0], 9);
    enable_read = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
